// File: rtl/execute_mdu_pkg.sv
// Shared op encodings, FSM states and the EX->MEM register bundle for execute_mdu.
package execute_mdu_pkg;

    localparam int MDOP_W = 8;
    localparam int MMOP_W = 8;

    localparam int MDOP_MULT  = 0;
    localparam int MDOP_MULTU = 1;
    localparam int MDOP_DIV   = 2;
    localparam int MDOP_DIVU  = 3;
    localparam int MDOP_MFHI  = 4;
    localparam int MDOP_MFLO  = 5;
    localparam int MDOP_MTHI  = 6;
    localparam int MDOP_MTLO  = 7;

    localparam int MMOP_LB  = 0;
    localparam int MMOP_LBU = 1;
    localparam int MMOP_LH  = 2;
    localparam int MMOP_LHU = 3;
    localparam int MMOP_LW  = 4;
    localparam int MMOP_SB  = 5;
    localparam int MMOP_SH  = 6;
    localparam int MMOP_SW  = 7;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_MUL  = 2'd1,
        MDU_DIV  = 2'd2,
        MDU_DONE = 2'd3
    } mdu_state_e;

    typedef struct packed {
        logic              valid;
        logic              wren;
        logic [4:0]        waddr;
        logic [31:0]       wdata;
        logic [31:0]       pc;
        logic [MMOP_W-1:0] memop;
        logic [1:0]        memaddr_low;
        logic              adel;
        logic              ades;
        logic [31:0]       badvaddr;
    } ex_out_t;

    // One restoring step on {rem, dividend}: shift, trial subtract, keep if non-negative.
    function automatic logic [63:0] div_step(input logic [63:0] rq, input logic [31:0] d);
        logic [32:0] r;
        logic [32:0] diff;
        r    = {rq[63:32], rq[31]};
        diff = r - {1'b0, d};
        if (!diff[32]) return {diff[31:0], rq[30:0], 1'b1};
        else           return {r[31:0], rq[30:0], 1'b0};
    endfunction

endpackage

// File: rtl/execute_mdu_div.sv
// Iterative restoring divider on operand magnitudes, DIV_BITS quotient bits per cycle.
module execute_mdu_div
    import execute_mdu_pkg::*;
#(
    parameter int DIV_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    localparam logic [4:0] LAST = 5'(32 / DIV_BITS - 1);

    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] rq_q, rq_d, rq_step;
    logic [31:0] dvs_q, dvs_d, dvd_q, dvd_d;
    logic        negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    assign a_neg  = signed_i & dividend_i[31];
    assign b_neg  = signed_i & divisor_i[31];
    assign a_mag  = a_neg ? -dividend_i : dividend_i;
    assign b_mag  = b_neg ? -divisor_i : divisor_i;
    assign done_o = busy_q & (cnt_q == LAST);

    always_comb begin
        rq_step = rq_q;
        for (int i = 0; i < DIV_BITS; i++) rq_step = div_step(rq_step, dvs_q);
    end

    // Result is taken from the final step combinationally so HI/LO load on the done edge.
    always_comb begin
        quot_o = negq_q ? -rq_step[31:0] : rq_step[31:0];
        rem_o  = negr_q ? -rq_step[63:32] : rq_step[63:32];
        if (dz_q) begin
            quot_o = 32'hFFFF_FFFF;
            rem_o  = dvd_q;
        end
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rq_d   = rq_q;
        dvs_d  = dvs_q;
        dvd_d  = dvd_q;
        negq_d = negq_q;
        negr_d = negr_q;
        dz_d   = dz_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rq_d   = {32'd0, a_mag};
            dvs_d  = b_mag;
            dvd_d  = dividend_i;
            negq_d = a_neg ^ b_neg;
            negr_d = a_neg;
            dz_d   = (divisor_i == 32'd0);
        end else if (busy_q) begin
            rq_d  = rq_step;
            cnt_d = cnt_q + 5'd1;
            if (abort_i || done_o) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rq_q   <= '0;
            dvs_q  <= '0;
            dvd_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rq_q   <= rq_d;
            dvs_q  <= dvs_d;
            dvd_q  <= dvd_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            dz_q   <= dz_d;
        end
    end

endmodule

// File: rtl/execute_mdu.sv
// EX stage: result select, SRAM request, misalignment check, EX->MEM registers, HI/LO MDU.
module execute_mdu
    import execute_mdu_pkg::*;
#(
    parameter int MUL_STAGES = 3,
    parameter int DIV_BITS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_flush_i,
    input  logic              ex_stall_i,
    input  logic              ex_valid_i,
    input  logic [31:0]       ex_pc_i,
    input  logic [31:0]       ex_opr1_i,
    input  logic [31:0]       ex_opr2_i,
    input  logic [31:0]       ex_rtvalue_i,
    input  logic [31:0]       ex_alures_i,
    input  logic              ex_wren_i,
    input  logic [4:0]        ex_waddr_i,
    input  logic [MDOP_W-1:0] ex_mduop_i,
    input  logic [MMOP_W-1:0] ex_memop_i,
    output logic              ex_stallreq_o,
    output logic              ex_valid_o,
    output logic              ex_wren_o,
    output logic [4:0]        ex_waddr_o,
    output logic [31:0]       ex_wdata_o,
    output logic [31:0]       ex_pc_o,
    output logic [MMOP_W-1:0] ex_memop_o,
    output logic [1:0]        ex_memaddr_low_o,
    output logic              ex_adel_o,
    output logic              ex_ades_o,
    output logic [31:0]       ex_badvaddr_o,
    output logic              ex_memen_o,
    output logic [3:0]        ex_memwen_o,
    output logic [31:0]       ex_memaddr_o,
    output logic [31:0]       ex_memwdata_o,
    output logic [31:0]       ex_wdata_bp_o
);

    localparam logic [1:0] MUL_LAST = 2'(MUL_STAGES - 1);

    mdu_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [32:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [63:0] mul_prod, mul_res;
    ex_out_t     out_q, out_d, out_n;
    logic        is_mul, is_div, advance, div_start, div_done, misalign;
    logic [31:0] wdata_nxt, div_quot, div_rem;
    logic [31:0] a;

    assign a         = ex_alures_i;
    assign is_mul    = ex_mduop_i[MDOP_MULT] | ex_mduop_i[MDOP_MULTU];
    assign is_div    = ex_mduop_i[MDOP_DIV] | ex_mduop_i[MDOP_DIVU];
    assign advance   = ~ex_stall_i & ~ex_flush_i & ex_valid_i;
    assign div_start = (state_q == MDU_IDLE) & ex_valid_i & ~ex_flush_i & is_div & ~is_mul;
    assign ex_stallreq_o = (state_q == MDU_MUL) | (state_q == MDU_DIV);

    assign wdata_nxt = ex_mduop_i[MDOP_MFHI] ? hi_q :
                       ex_mduop_i[MDOP_MFLO] ? lo_q : ex_alures_i;
    assign ex_wdata_bp_o = wdata_nxt;

    assign misalign = ((ex_memop_i[MMOP_LH] | ex_memop_i[MMOP_LHU] | ex_memop_i[MMOP_SH]) & a[0])
                    | ((ex_memop_i[MMOP_LW] | ex_memop_i[MMOP_SW]) & (|a[1:0]));
    assign ex_memen_o    = (|ex_memop_i) & ~misalign & ~ex_flush_i & ex_valid_i;
    assign ex_memaddr_o  = {a[31:2], 2'b00};
    assign ex_memwdata_o = ex_memop_i[MMOP_SB] ? {4{ex_rtvalue_i[7:0]}} :
                           ex_memop_i[MMOP_SH] ? {2{ex_rtvalue_i[15:0]}} : ex_rtvalue_i;

    always_comb begin
        ex_memwen_o = 4'b0000;
        if (ex_memen_o) begin
            if (ex_memop_i[MMOP_SB])      ex_memwen_o = 4'b0001 << a[1:0];
            else if (ex_memop_i[MMOP_SH]) ex_memwen_o = a[1] ? 4'b1100 : 4'b0011;
            else if (ex_memop_i[MMOP_SW]) ex_memwen_o = 4'b1111;
        end
    end

    // Low 64 bits of the sign-extended product are exact for both signed and unsigned.
    assign mul_prod = {{31{mul_a_q[32]}}, mul_a_q} * {{31{mul_b_q[32]}}, mul_b_q};

    generate
        if (MUL_STAGES == 1) begin : g_mul_comb
            assign mul_res = mul_prod;
        end else begin : g_mul_pipe
            logic [63:0] pipe_q [MUL_STAGES-1];
            always_ff @(posedge clk) begin
                pipe_q[0] <= mul_prod;
                for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
            assign mul_res = pipe_q[MUL_STAGES-2];
        end
    endgenerate

    execute_mdu_div #(.DIV_BITS(DIV_BITS)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .abort_i    (ex_flush_i),
        .signed_i   (ex_mduop_i[MDOP_DIV]),
        .dividend_i (ex_opr1_i),
        .divisor_i  (ex_opr2_i),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (advance && ex_mduop_i[MDOP_MTHI]) hi_d = ex_opr1_i;
        if (advance && ex_mduop_i[MDOP_MTLO]) lo_d = ex_opr1_i;
        unique case (state_q)
            MDU_IDLE: begin
                if (ex_valid_i && !ex_flush_i && is_mul) begin
                    state_d = MDU_MUL;
                    cnt_d   = '0;
                    mul_a_d = {ex_mduop_i[MDOP_MULT] & ex_opr1_i[31], ex_opr1_i};
                    mul_b_d = {ex_mduop_i[MDOP_MULT] & ex_opr2_i[31], ex_opr2_i};
                end else if (div_start) begin
                    state_d = MDU_DIV;
                    cnt_d   = '0;
                end
            end
            MDU_MUL: begin
                if (ex_flush_i) state_d = MDU_IDLE;
                else if (cnt_q == MUL_LAST) begin
                    state_d = MDU_DONE;
                    hi_d    = mul_res[63:32];
                    lo_d    = mul_res[31:0];
                end else cnt_d = cnt_q + 2'd1;
            end
            MDU_DIV: begin
                if (ex_flush_i) state_d = MDU_IDLE;
                else if (div_done) begin
                    state_d = MDU_DONE;
                    hi_d    = div_rem;
                    lo_d    = div_quot;
                end
            end
            MDU_DONE: if (ex_flush_i || !ex_stall_i) state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase
    end

    always_comb begin
        out_n.valid       = ex_valid_i;
        out_n.wren        = ex_wren_i;
        out_n.waddr       = ex_waddr_i;
        out_n.wdata       = wdata_nxt;
        out_n.pc          = ex_pc_i;
        out_n.memop       = ex_memop_i;
        out_n.memaddr_low = a[1:0];
        out_n.adel        = ex_valid_i & misalign
                          & (ex_memop_i[MMOP_LH] | ex_memop_i[MMOP_LHU] | ex_memop_i[MMOP_LW]);
        out_n.ades        = ex_valid_i & misalign & (ex_memop_i[MMOP_SH] | ex_memop_i[MMOP_SW]);
        out_n.badvaddr    = (out_n.adel | out_n.ades) ? a : 32'd0;
        out_d = out_q;
        if (!ex_stall_i) out_d = (ex_flush_i || ex_stallreq_o) ? '0 : out_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            out_q   <= out_d;
        end
    end

    assign ex_valid_o       = out_q.valid;
    assign ex_wren_o        = out_q.wren;
    assign ex_waddr_o       = out_q.waddr;
    assign ex_wdata_o       = out_q.wdata;
    assign ex_pc_o          = out_q.pc;
    assign ex_memop_o       = out_q.memop;
    assign ex_memaddr_low_o = out_q.memaddr_low;
    assign ex_adel_o        = out_q.adel;
    assign ex_ades_o        = out_q.ades;
    assign ex_badvaddr_o    = out_q.badvaddr;

endmodule

// File: tb/tb_execute_mdu.sv
// Directed bench for execute_mdu: ALU path, stalls/flushes, mult/div HI/LO, misalignment.
module tb_execute_mdu;

    logic        clk, rst, flush, stall, valid, wren;
    logic [31:0] pc, opr1, opr2, rtv, alures;
    logic [4:0]  waddr;
    logic [7:0]  mduop, memop;
    logic        stallreq, valid_o, wren_o, adel_o, ades_o, memen_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o, pc_o, badvaddr_o, memaddr_o, memwdata_o, wdata_bp_o;
    logic [7:0]  memop_o;
    logic [1:0]  memaddr_low_o;
    logic [3:0]  memwen_o;

    int total = 0;
    int bad   = 0;
    int n;

    execute_mdu #(.MUL_STAGES(3), .DIV_BITS(1)) dut (
        .clk(clk), .rst(rst), .ex_flush_i(flush), .ex_stall_i(stall), .ex_valid_i(valid),
        .ex_pc_i(pc), .ex_opr1_i(opr1), .ex_opr2_i(opr2), .ex_rtvalue_i(rtv),
        .ex_alures_i(alures), .ex_wren_i(wren), .ex_waddr_i(waddr), .ex_mduop_i(mduop),
        .ex_memop_i(memop), .ex_stallreq_o(stallreq), .ex_valid_o(valid_o),
        .ex_wren_o(wren_o), .ex_waddr_o(waddr_o), .ex_wdata_o(wdata_o), .ex_pc_o(pc_o),
        .ex_memop_o(memop_o), .ex_memaddr_low_o(memaddr_low_o), .ex_adel_o(adel_o),
        .ex_ades_o(ades_o), .ex_badvaddr_o(badvaddr_o), .ex_memen_o(memen_o),
        .ex_memwen_o(memwen_o), .ex_memaddr_o(memaddr_o), .ex_memwdata_o(memwdata_o),
        .ex_wdata_bp_o(wdata_bp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        valid = 0; wren = 0; waddr = 0; pc = 0; opr1 = 0; opr2 = 0;
        rtv = 0; alures = 0; mduop = 0; memop = 0;
    endtask

    // HI/LO are visible only through the bypass value of mfhi/mflo.
    task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        valid = 0;
        mduop = 8'h10; #1; chk({tag, "_hi"}, wdata_bp_o, hi);
        mduop = 8'h20; #1; chk({tag, "_lo"}, wdata_bp_o, lo);
        mduop = 8'h00;
    endtask

    task automatic issue_mdu(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y);
        clear_in();
        valid = 1; mduop = op; opr1 = x; opr2 = y;
    endtask

    task automatic wait_busy(output int cycles);
        cycles = 0;
        while (stallreq && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    initial begin
        rst = 1; flush = 0; stall = 0;
        clear_in();
        tick(); tick();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        check_hilo("rst", 32'd0, 32'd0);
        rst = 0;

        // Plain ALU instruction, then stall-hold and flush-vs-stall.
        valid = 1; wren = 1; waddr = 5'd3; alures = 32'h1234_5678; pc = 32'hBFC0_0000;
        #1 chk("alu_bp", wdata_bp_o, 32'h1234_5678);
        tick();
        chk("alu_wdata", wdata_o, 32'h1234_5678);
        chk("alu_waddr", 32'(waddr_o), 32'd3);
        chk("alu_pc", pc_o, 32'hBFC0_0000);
        stall = 1; flush = 1; alures = 32'hDEAD_BEEF;
        tick(); tick();
        chk("stall_hold", wdata_o, 32'h1234_5678);
        stall = 0;
        tick();
        chk("flush_bubble_v", 32'(valid_o), 32'd0);
        chk("flush_bubble_d", wdata_o, 32'd0);
        flush = 0;

        issue_mdu(8'h40, 32'h11, 0); tick();
        issue_mdu(8'h80, 32'h22, 0); tick();
        check_hilo("mthi_mtlo", 32'h11, 32'h22);

        // mult -3 * 5
        issue_mdu(8'h01, 32'hFFFF_FFFD, 32'd5); tick();
        wait_busy(n);
        chk("mult_cycles", n, 32'd3);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        tick();

        // divu 100 / 7, then mflo reaches MEM
        issue_mdu(8'h08, 32'd100, 32'd7); tick();
        wait_busy(n);
        chk("divu_cycles", n, 32'd32);
        check_hilo("divu", 32'd2, 32'd14);
        tick();
        clear_in(); valid = 1; wren = 1; mduop = 8'h20; tick();
        chk("mflo_wdata", wdata_o, 32'd14);

        issue_mdu(8'h04, 32'h0000_000A, 32'd0); tick();
        wait_busy(n);
        check_hilo("div0", 32'h0000_000A, 32'hFFFF_FFFF);
        tick();
        issue_mdu(8'h04, 32'h8000_0000, 32'hFFFF_FFFF); tick();
        wait_busy(n);
        check_hilo("divovf", 32'd0, 32'h8000_0000);
        tick();

        // Flush on the 10th busy cycle of a divide, then an immediate new divu.
        issue_mdu(8'h08, 32'd50, 32'd5); tick();
        repeat (9) tick();
        chk("flush_pre_busy", 32'(stallreq), 32'd1);
        flush = 1; tick(); flush = 0;
        clear_in();
        chk("flush_stallreq", 32'(stallreq), 32'd0);
        check_hilo("flush", 32'd0, 32'h8000_0000);
        issue_mdu(8'h08, 32'd9, 32'd3); tick();
        wait_busy(n);
        chk("divu93_cycles", n, 32'd32);
        check_hilo("divu93", 32'd0, 32'd3);
        tick();

        // Memory requests and misalignment
        clear_in(); valid = 1; memop = 8'h10; alures = 32'h0000_1002;
        #1 chk("lw_mis_memen", 32'(memen_o), 32'd0);
        tick();
        chk("lw_adel", 32'(adel_o), 32'd1);
        chk("lw_badv", badvaddr_o, 32'h0000_1002);
        clear_in(); valid = 1; memop = 8'h40; alures = 32'h0000_1002; rtv = 32'h0000_ABCD;
        #1;
        chk("sh_memen", 32'(memen_o), 32'd1);
        chk("sh_memwen", 32'(memwen_o), 32'hC);
        chk("sh_wdata", memwdata_o, 32'hABCD_ABCD);
        chk("sh_addr", memaddr_o, 32'h0000_1000);
        tick();
        chk("sh_ades", 32'(ades_o), 32'd0);
        clear_in(); valid = 1; memop = 8'h20; alures = 32'h0000_1003; rtv = 32'h1234_5678;
        #1;
        chk("sb_memwen", 32'(memwen_o), 32'h8);
        chk("sb_wdata", memwdata_o, 32'h7878_7878);
        memop = 8'h80; alures = 32'h0000_1001;
        #1 chk("sw_mis_memwen", 32'(memwen_o), 32'h0);
        tick();
        chk("sw_ades", 32'(ades_o), 32'd1);

        // Downstream stall held in DONE
        issue_mdu(8'h02, 32'd7, 32'd6); tick();
        wait_busy(n);
        stall = 1;
        repeat (3) begin
            tick();
            chk("done_stall_sreq", 32'(stallreq), 32'd0);
        end
        check_hilo("done_stall", 32'd0, 32'd42);
        stall = 0; tick();
        chk("done_release_sreq", 32'(stallreq), 32'd0);
        issue_mdu(8'h40, 32'h77, 0); tick();
        clear_in();
        chk("done_release_sreq2", 32'(stallreq), 32'd0);
        check_hilo("post_done", 32'h77, 32'd42);

        // Reset in the middle of a divide
        issue_mdu(8'h08, 32'd100, 32'd7); tick();
        repeat (4) tick();
        rst = 1; tick(); rst = 0;
        clear_in();
        chk("rst_mid_sreq", 32'(stallreq), 32'd0);
        chk("rst_mid_valid", 32'(valid_o), 32'd0);
        check_hilo("rst_mid", 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
